frame_reader_axis: RTL and testbench

//  Consumer end of the read_frame interface: the C2H DMA side that pulls frames from a frame

---
 rtl/frame_reader_axis.sv | 255 +++++++++++++++++++++++++
 tb/tb_frame_reader_axis.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader_axis.sv
// frame_reader_axis
//   Consumer end of the read_frame interface (C2H DMA side). Pulls frames
//   beat by beat from a frame source and re-emits them as AXI4-Stream. The
//   read latency of the source (FRAME_PIPELINE cycles) is absorbed by an
//   output FIFO. Reads are credit gated, so the FIFO can never overflow.
//   The block adds tkeep/tlast/tid/tdest and flags bad lengths and frames
//   that start without sop.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   read_frame_ready/len/tag/sop  source status: beat available, frame length
//                                 (bytes), frame tag, first beat of a frame
//   read_frame_enb           read strobe, one beat per asserted cycle
//   read_frame_tdata         beat data, FRAME_PIPELINE cycles after enb
//   m_axis_*                 AXI4-Stream master (tid = tag, tdest = length)
//   status_len_err           1-cycle pulse: len==0 or len>MAX_FRAME_LEN
//   status_sync_err          1-cycle pulse: frame start seen with sop=0
//   busy                     FSM active, beats in flight, or FIFO not empty
//
// Optional build macro FRAME_READER_STATS_EN adds the stat_frames,
// stat_bytes and stat_errs wrapping counters.
module frame_reader_axis #(
  parameter int FRAME_DATA_WIDTH = 512,
  parameter int LEN_WIDTH        = 16,
  parameter int TAG_WIDTH        = 8,
  parameter int FRAME_PIPELINE   = 1,
  parameter int FIFO_DEPTH       = 8,
  parameter int MAX_FRAME_LEN    = 2048
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          read_frame_ready,
  input  logic [LEN_WIDTH-1:0]          read_frame_len,
  input  logic [TAG_WIDTH-1:0]          read_frame_tag,
  input  logic                          read_frame_sop,
  output logic                          read_frame_enb,
  input  logic [FRAME_DATA_WIDTH-1:0]   read_frame_tdata,
  output logic [FRAME_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [FRAME_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [TAG_WIDTH-1:0]          m_axis_tid,
  output logic [LEN_WIDTH-1:0]          m_axis_tdest,
  output logic                          status_len_err,
  output logic                          status_sync_err,
`ifdef FRAME_READER_STATS_EN
  output logic [31:0]                   stat_frames,
  output logic [31:0]                   stat_bytes,
  output logic [15:0]                   stat_errs,
`endif
  output logic                          busy
);
  localparam int BYTES = FRAME_DATA_WIDTH / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH+1)'(MAX_FRAME_LEN);
  localparam logic [CW:0]        DEPTH_L = (CW+1)'(FIFO_DEPTH);

  // Per-beat sideband, travels with the data through the pipe and FIFO so a
  // new frame can be latched while the previous one is still in flight.
  typedef struct packed {
    logic                 last;
    logic [BYTES-1:0]     keep;
    logic [TAG_WIDTH-1:0] tid;
    logic [LEN_WIDTH-1:0] tdest;
  } side_t;

  typedef enum logic {S_IDLE, S_DATA} state_t;
  state_t state, state_nxt;

  logic [LEN_WIDTH-1:0] len_q, nbeats_q, beat_cnt, nbeats_d;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [LEN_WIDTH:0]   len_up;
  logic                 latch, enb, push0, last0, len_err, sync_err;
  logic [BYTES-1:0]     keep_last;
  side_t                side0, out_side, head;
  logic                 out_vld;
  logic [CW:0]          inflight;
  logic [CW-1:0]        count;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 credit_ok, pop;

  // ceil(len/BYTES), with an empty frame still occupying one beat
  assign len_up = {1'b0, read_frame_len} + (LEN_WIDTH+1)'(BYTES - 1);
  always_comb begin
    nbeats_d = LEN_WIDTH'(len_up >> BW);
    if (read_frame_len == '0) nbeats_d = LEN_WIDTH'(1);
  end

  // Credit: FIFO entries plus beats already requested must leave a free slot.
  assign credit_ok = ({1'b0, count} + inflight) < DEPTH_L;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    enb       = 1'b0;
    push0     = 1'b0;
    last0     = 1'b0;
    len_err   = 1'b0;
    sync_err  = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: if (read_frame_ready) begin
          if (read_frame_sop) begin
            latch     = 1'b1;
            state_nxt = S_DATA;
            len_err   = (read_frame_len == '0) || ({1'b0, read_frame_len} > MAX_LEN);
          end else begin
            // stray beat: consume it to resynchronise, but never store it
            sync_err = 1'b1;
            enb      = 1'b1;
          end
        end
        S_DATA: if (read_frame_ready && credit_ok) begin
          enb   = 1'b1;
          push0 = 1'b1;
          last0 = (beat_cnt == nbeats_q - LEN_WIDTH'(1));
          if (last0) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      tag_q    <= '0;
      nbeats_q <= '0;
      beat_cnt <= '0;
    end else if (latch) begin
      len_q    <= read_frame_len;
      tag_q    <= read_frame_tag;
      nbeats_q <= nbeats_d;
      beat_cnt <= '0;
    end else if (push0) begin
      beat_cnt <= beat_cnt + LEN_WIDTH'(1);
    end
  end

  // Last-beat keep: low (len mod BYTES) bytes; full when the remainder is 0,
  // except for an empty frame which keeps nothing.
  always_comb begin
    keep_last = '0;
    for (int i = 0; i < BYTES; i++)
      keep_last[i] = (len_q[BW-1:0] == '0) ? (len_q != '0) : (BW'(i) < len_q[BW-1:0]);
  end

  always_comb begin
    side0.last  = last0;
    side0.keep  = last0 ? keep_last : '1;
    side0.tid   = tag_q;
    side0.tdest = len_q;
  end

  // In-flight tracking, aligned with the source read latency.
  generate
    if (FRAME_PIPELINE == 0) begin : g_nopipe
      assign out_vld  = push0;
      assign out_side = side0;
      assign inflight = '0;
    end else begin : g_pipe
      logic [FRAME_PIPELINE-1:0] vld_pipe;
      side_t                     side_pipe [FRAME_PIPELINE];

      always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else begin
          vld_pipe[0] <= push0;
          for (int i = 1; i < FRAME_PIPELINE; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      always_ff @(posedge clk) begin
        side_pipe[0] <= side0;
        for (int i = 1; i < FRAME_PIPELINE; i++) side_pipe[i] <= side_pipe[i-1];
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < FRAME_PIPELINE; i++) inflight = inflight + (CW+1)'(vld_pipe[i]);
      end

      assign out_vld  = vld_pipe[FRAME_PIPELINE-1];
      assign out_side = side_pipe[FRAME_PIPELINE-1];
    end
  endgenerate

  // Output FIFO
  logic [FRAME_DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  side_t                       side_mem [FIFO_DEPTH];

  assign pop = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (out_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({out_vld, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (out_vld) begin
      data_mem[wr_ptr] <= read_frame_tdata;
      side_mem[wr_ptr] <= out_side;
    end
  end

  // Head of FIFO drives the stream; zeroed while empty so idle outputs are 0.
  assign head          = side_mem[rd_ptr];
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? data_mem[rd_ptr] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? head.keep  : '0;
  assign m_axis_tlast  = m_axis_tvalid && head.last;
  assign m_axis_tid    = m_axis_tvalid ? head.tid   : '0;
  assign m_axis_tdest  = m_axis_tvalid ? head.tdest : '0;

  assign read_frame_enb  = enb;
  assign status_len_err  = len_err;
  assign status_sync_err = sync_err;
  assign busy            = (state != S_IDLE) || (inflight != '0) || (count != '0);

`ifdef FRAME_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_bytes  <= '0;
      stat_errs   <= '0;
    end else begin
      if (pop && m_axis_tlast) begin
        stat_frames <= stat_frames + 32'd1;
        stat_bytes  <= stat_bytes + 32'(m_axis_tdest);
      end
      if (len_err || sync_err) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_reader_axis.sv
// Bench for frame_reader_axis. Two instances run the same directed scenario,
// one with a 1-cycle and one with a 3-cycle source read latency. Each has a
// source model (queue of beats), an expected-beat queue derived from the
// frames offered, and a per-cycle compare process.
module tb_frame_reader_axis;
  localparam int DW    = 512;
  localparam int BYTES = DW / 8;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic [15:0]   len;
    logic [7:0]    tag;
  } sbeat_t;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic             last;
    logic [BYTES-1:0] keep;
    logic [7:0]       tid;
    logic [15:0]      tdest;
  } ebeat_t;

  logic       clk;
  logic [1:0] done;
  int         n_pass = 0;
  int         n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int P = (g == 0) ? 1 : 3;

    logic             rst;
    logic             read_frame_ready, read_frame_sop, read_frame_enb;
    logic [15:0]      read_frame_len;
    logic [7:0]       read_frame_tag;
    logic [DW-1:0]    read_frame_tdata;
    logic [DW-1:0]    m_axis_tdata;
    logic [BYTES-1:0] m_axis_tkeep;
    logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [7:0]       m_axis_tid;
    logic [15:0]      m_axis_tdest;
    logic             status_len_err, status_sync_err, busy;

    frame_reader_axis #(
      .FRAME_DATA_WIDTH(DW), .LEN_WIDTH(16), .TAG_WIDTH(8),
      .FRAME_PIPELINE(P), .FIFO_DEPTH(DEPTH), .MAX_FRAME_LEN(2048)
    ) dut (
      .clk(clk), .rst(rst),
      .read_frame_ready(read_frame_ready), .read_frame_len(read_frame_len),
      .read_frame_tag(read_frame_tag), .read_frame_sop(read_frame_sop),
      .read_frame_enb(read_frame_enb), .read_frame_tdata(read_frame_tdata),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
      .m_axis_tdest(m_axis_tdest), .status_len_err(status_len_err),
      .status_sync_err(status_sync_err), .busy(busy)
    );

    sbeat_t src_q[$];
    ebeat_t exp_q[$];
    int     nenb, nout, nlast, nlen, nsync;
    logic   tr_val, tr_rand;
    logic [BYTES-1:0] last_keep;
    logic             last_last;
    logic [7:0]       last_tid;
    logic [15:0]      last_tdest;

    task automatic check(string name, logic [639:0] act, logic [639:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [pipe=%0d] got=%0h want=%0h", name, P, act, exp);
    endtask

    task automatic clr_cnt();
      nenb = 0; nout = 0; nlast = 0; nlen = 0; nsync = 0;
    endtask

    // Offer one frame to the source and record the beats it must produce.
    task automatic send_frame(int len, int tag);
      int nb;
      sbeat_t s;
      ebeat_t e;
      nb = (len == 0) ? 1 : (len + BYTES - 1) / BYTES;
      for (int i = 0; i < nb; i++) begin
        s.data = rnd512(); s.sop = (i == 0); s.len = 16'(len); s.tag = 8'(tag);
        src_q.push_back(s);
        e.data = s.data; e.last = (i == nb - 1); e.keep = '1;
        if (e.last) begin
          if (len == 0)               e.keep = '0;
          else if (len % BYTES != 0)  e.keep = (64'd1 << (len % BYTES)) - 64'd1;
        end
        e.tid = 8'(tag); e.tdest = 16'(len);
        exp_q.push_back(e);
      end
    endtask

    // A beat with sop=0 while no frame is open; it must be dropped.
    task automatic send_stray();
      sbeat_t s;
      s.data = rnd512(); s.sop = 1'b0; s.len = 16'd64; s.tag = 8'hEE;
      src_q.push_back(s);
    endtask

    task automatic wait_idle(string name, int max);
      int  n;
      logic ok;
      n = 0; ok = 1'b0;
      while (n < max && !ok) begin
        @(negedge clk);
        ok = (src_q.size() == 0) && (exp_q.size() == 0) && !busy;
        n++;
      end
      check($sformatf("%s_drain", name), ok, 1'b1);
      repeat (2) @(negedge clk);
    endtask

    // Source: pops a beat per enb and returns its data P cycles later.
    initial begin : src
      logic          took;
      logic [DW-1:0] dpipe [4];
      logic [DW-1:0] nd;
      sbeat_t        b;
      read_frame_ready = 1'b0; read_frame_sop = 1'b0;
      read_frame_len = '0; read_frame_tag = '0; read_frame_tdata = '0;
      for (int i = 0; i < 4; i++) dpipe[i] = '0;
      forever begin
        @(negedge clk);
        took = read_frame_enb;
        @(posedge clk);
        #1;
        nd = {16{32'hDEADBEEF}};
        if (rst) begin
          took = 1'b0;
          for (int i = 0; i < 4; i++) dpipe[i] = '0;
        end
        if (took && src_q.size() > 0) begin
          b  = src_q.pop_front();
          nd = b.data;
        end
        for (int i = P - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
        dpipe[0] = nd;
        read_frame_tdata = dpipe[P-1];
        if (src_q.size() > 0) begin
          read_frame_ready = 1'b1;
          read_frame_sop   = src_q[0].sop;
          read_frame_len   = src_q[0].len;
          read_frame_tag   = src_q[0].tag;
        end else begin
          read_frame_ready = 1'b0;
          read_frame_sop   = 1'b0;
        end
      end
    end

    initial begin : trdrv
      m_axis_tready = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        m_axis_tready = tr_rand ? 1'($urandom_range(0, 1)) : tr_val;
      end
    end

    // Compare process: every transfer against the expected queue, held
    // outputs stable under backpressure, enb only when the source is ready.
    initial begin : chk
      logic         held;
      logic [639:0] prev, cur;
      ebeat_t       e;
      held = 1'b0; prev = '0;
      forever begin
        @(negedge clk);
        cur = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tid, m_axis_tdest, m_axis_tdata};
        if (rst) begin
          held = 1'b0;
        end else begin
          if (held) check("hold_stable", cur, prev);
          if (m_axis_tvalid && m_axis_tready) begin
            nout++;
            if (m_axis_tlast) nlast++;
            last_keep = m_axis_tkeep; last_last = m_axis_tlast;
            last_tid  = m_axis_tid;   last_tdest = m_axis_tdest;
            check("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("beat_data", m_axis_tdata, e.data);
              check("beat_side", {m_axis_tlast, m_axis_tkeep, m_axis_tid, m_axis_tdest},
                                 {e.last, e.keep, e.tid, e.tdest});
            end
          end
          if (read_frame_enb) begin
            nenb++;
            check("enb_needs_ready", read_frame_ready, 1'b1);
          end
          if (status_len_err)  nlen++;
          if (status_sync_err) nsync++;
          held = m_axis_tvalid && !m_axis_tready;
          prev = cur;
        end
      end
    end

    initial begin : main
      int t_enb, t_vld, cyc, ne;
      rst = 1'b1; tr_val = 1'b0; tr_rand = 1'b0;
      clr_cnt();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tid, m_axis_tdest,
                           m_axis_tdata, read_frame_enb, status_len_err, status_sync_err, busy}, '0);

      // 1: single full beat, latency enb -> tvalid
      tr_val = 1'b1; clr_cnt();
      send_frame(64, 5);
      t_enb = -1; t_vld = -1; cyc = 0;
      while (cyc < 60 && t_vld < 0) begin
        @(negedge clk);
        if (read_frame_enb && t_enb < 0) t_enb = cyc;
        if (m_axis_tvalid && t_vld < 0) t_vld = cyc;
        cyc++;
      end
      check("t1_latency", t_vld - t_enb, P + 1);
      wait_idle("t1", 100);
      check("t1_enb", nenb, 1);
      check("t1_beats", nout, 1);
      check("t1_side", {last_last, last_keep, last_tid, last_tdest},
                       {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd5, 16'd64});

      // 2: partial last beat
      clr_cnt();
      send_frame(100, 7);
      wait_idle("t2", 100);
      check("t2_enb", nenb, 2);
      check("t2_beats", nout, 2);
      check("t2_side", {last_last, last_keep, last_tid, last_tdest},
                       {1'b1, 64'h0000_000F_FFFF_FFFF, 8'd7, 16'd100});

      // 3: max frame under backpressure, reads stop at FIFO credit
      clr_cnt(); tr_val = 1'b0;
      send_frame(2048, 9);
      repeat (50) @(negedge clk);
      check("t3_credit_enb", nenb, DEPTH);
      check("t3_no_out", nout, 0);
      tr_rand = 1'b1;
      wait_idle("t3", 2000);
      tr_rand = 1'b0; tr_val = 1'b1;
      check("t3_beats", nout, 32);
      check("t3_enb", nenb, 32);
      check("t3_tlast", nlast, 1);

      // 4: stray beat without sop, then a normal frame
      clr_cnt();
      send_stray();
      send_frame(128, 3);
      wait_idle("t4", 200);
      check("t4_sync_err", nsync, 1);
      check("t4_len_err", nlen, 0);
      check("t4_enb", nenb, 3);
      check("t4_beats", nout, 2);

      // 5: empty frame then oversize frame
      clr_cnt();
      send_frame(0, 11);
      send_frame(3000, 12);
      wait_idle("t5", 500);
      check("t5_len_err", nlen, 2);
      check("t5_beats", nout, 48);
      check("t5_tlast", nlast, 2);
      check("t5_side", {last_last, last_keep, last_tid, last_tdest},
                       {1'b1, 64'h00FF_FFFF_FFFF_FFFF, 8'd12, 16'd3000});

      // 6: reset in the middle of a frame, then a fresh frame
      clr_cnt();
      send_frame(2048, 13);
      ne = 0; cyc = 0;
      while (ne < 10 && cyc < 300) begin
        @(negedge clk);
        if (read_frame_enb) ne++;
        cyc++;
      end
      check("t6_reached_beat10", ne, 10);
      #1 rst = 1'b1;
      src_q.delete();
      exp_q.delete();
      @(negedge clk);
      check("t6_reset_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tid, m_axis_tdest,
                              m_axis_tdata, read_frame_enb, status_len_err, status_sync_err, busy}, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      clr_cnt();
      send_frame(200, 14);
      wait_idle("t6", 200);
      check("t6_beats", nout, 4);
      check("t6_side", {last_last, last_keep, last_tid, last_tdest},
                       {1'b1, 64'h0000_0000_0000_00FF, 8'd14, 16'd200});
      done[g] = 1'b1;
    end
  end

  initial begin
    done = '0;
    fork
      wait (&done);
      #400000;
    join_any
    if (!(&done)) begin
      n_total++;
      $display("FAIL timeout: scenarios incomplete done=%b want=11", done);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
